// File: rtl/bus_sequencer_if.sv
// Bus between the instruction sequencer and its environment: ROM data, run control,
// the active-low register-file enables/strobes and status.
interface bus_sequencer_if;
    logic       RUN;
    logic       STEP;
    logic [7:0] INSTR;
    logic       CARRY;
    logic [7:0] IR;
    logic       nIRD_OUT;
    logic       nIRU_OUT;
    logic       nJRD_OUT;
    logic       nJRU_OUT;
    logic       nORD_ST;
    logic       nORU_ST;
    logic       nJRD_ST;
    logic       nJRU_ST;
    logic       nPC_OPEN;
    logic       nPC_LD;
    logic       BUSY;
    logic       DONE;
    logic       ILLEGAL;

    modport master (
        input  RUN, STEP, INSTR, CARRY,
        output IR, nIRD_OUT, nIRU_OUT, nJRD_OUT, nJRU_OUT,
               nORD_ST, nORU_ST, nJRD_ST, nJRU_ST,
               nPC_OPEN, nPC_LD, BUSY, DONE, ILLEGAL
    );

    modport slave (
        output RUN, STEP, INSTR, CARRY,
        input  IR, nIRD_OUT, nIRU_OUT, nJRD_OUT, nJRU_OUT,
               nORD_ST, nORU_ST, nJRD_ST, nJRU_ST,
               nPC_OPEN, nPC_LD, BUSY, DONE, ILLEGAL
    );
endinterface

// File: rtl/bus_sequencer.sv
// Four-phase instruction sequencer: fetches a byte, drives LOADBUS source enables and
// register strobes, then increments or loads the PC.
//
//  state | meaning
//  IDLE  | waiting for RUN=1 or a STEP rising edge
//  FETCH | INSTR/CARRY captured on the edge ending this cycle
//  SRC   | source enable driven, bus settling for SETTLE_CYCLES
//  STORE | store strobe low, register captures on the closing edge
//  ADV   | PC increment or load, DONE pulse
//  HALT  | parked after an illegal opcode until reset
module bus_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ILLEGAL_HALT  = 0
) (
    input  logic            CLK,
    input  logic            RST,
    bus_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SRC,
        S_STORE,
        S_ADV,
        S_HALT
    } state_t;

    localparam logic [2:0] SETTLE_LOAD     = 3'(SETTLE_CYCLES - 1);
    localparam bit         HALT_ON_ILLEGAL = (ILLEGAL_HALT != 0);

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       carry_q, carry_d;
    logic [2:0] settle_q, settle_d;
    logic       step_q, step_d;

    logic [3:0] op;
    logic       op_illegal;
    logic       use_ird;
    logic       use_jrd;
    logic       jump_taken;
    logic       step_edge;

    assign op         = ir_q[7:4];
    assign op_illegal = op[3];
    assign use_ird    = (op >= 4'd1) && (op <= 4'd4);
    assign use_jrd    = (op == 4'd5);
    assign jump_taken = (op == 4'd6) || ((op == 4'd7) && !carry_q);
    assign step_edge  = bus.STEP && !step_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            ir_q     <= 8'h00;
            carry_q  <= 1'b0;
            settle_q <= 3'd0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            carry_q  <= carry_d;
            settle_q <= settle_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        carry_d  = carry_q;
        settle_d = settle_q;
        step_d   = bus.STEP;
        case (state_q)
            S_IDLE: begin
                if (bus.RUN || step_edge) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d     = bus.INSTR;
                carry_d  = bus.CARRY;
                settle_d = SETTLE_LOAD;
                state_d  = S_SRC;
            end
            S_SRC: begin
                // Halting leaves SRC right after the ILLEGAL pulse, so no ADV ever runs.
                if (op_illegal && HALT_ON_ILLEGAL) begin
                    state_d = S_HALT;
                end else if (settle_q == 3'd0) begin
                    state_d = S_STORE;
                end else begin
                    settle_d = settle_q - 3'd1;
                end
            end
            S_STORE: state_d = S_ADV;
            S_ADV:   state_d = bus.RUN ? S_FETCH : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    logic src_phase;
    logic store_phase;
    logic adv_phase;
    logic ird_out_n, jrd_out_n;
    logic ord_st_n, oru_st_n, jrd_st_n, jru_st_n;
    logic pc_open_n, pc_ld_n;

    assign src_phase   = (state_q == S_SRC) || (state_q == S_STORE);
    assign store_phase = (state_q == S_STORE);
    assign adv_phase   = (state_q == S_ADV);

    // Outputs decode straight from reset flops so reset releases every strobe at once.
    always_comb begin
        ird_out_n = 1'b1;
        jrd_out_n = 1'b1;
        ord_st_n  = 1'b1;
        oru_st_n  = 1'b1;
        jrd_st_n  = 1'b1;
        jru_st_n  = 1'b1;
        pc_open_n = 1'b1;
        pc_ld_n   = 1'b1;
        if (src_phase && use_ird) ird_out_n = 1'b0;
        if (src_phase && use_jrd) jrd_out_n = 1'b0;
        if (store_phase) begin
            case (op)
                4'd1:    ord_st_n = 1'b0;
                4'd2:    oru_st_n = 1'b0;
                4'd3:    jrd_st_n = 1'b0;
                4'd4:    jru_st_n = 1'b0;
                4'd5:    ord_st_n = 1'b0;
                default: ;
            endcase
        end
        if (adv_phase) begin
            if (jump_taken) pc_ld_n   = 1'b0;
            else            pc_open_n = 1'b0;
        end
    end

    assign bus.IR       = ir_q;
    assign bus.nIRD_OUT = ird_out_n;
    assign bus.nIRU_OUT = 1'b1;
    assign bus.nJRD_OUT = jrd_out_n;
    assign bus.nJRU_OUT = 1'b1;
    assign bus.nORD_ST  = ord_st_n;
    assign bus.nORU_ST  = oru_st_n;
    assign bus.nJRD_ST  = jrd_st_n;
    assign bus.nJRU_ST  = jru_st_n;
    assign bus.nPC_OPEN = pc_open_n;
    assign bus.nPC_LD   = pc_ld_n;
    assign bus.BUSY     = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.DONE     = adv_phase;
    assign bus.ILLEGAL  = (state_q == S_SRC) && op_illegal && (settle_q == SETTLE_LOAD);

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: expected per-instruction bus activity is queued
// when an instruction is presented and compared when the DUT pulses DONE.
module tb_bus_sequencer;

    localparam int S = 2;

    logic CLK;
    logic RST;

    bus_sequencer_if bif ();

    bus_sequencer #(
        .SETTLE_CYCLES(S),
        .ILLEGAL_HALT (1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] ir;
        int         ird;
        int         jrd;
        logic [3:0] st_mask;
        int         st_cnt;
        logic [1:0] pc;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    function automatic void push_exp(input logic [7:0] ins, input logic cy);
        exp_t       e;
        logic [3:0] op;
        op        = ins[7:4];
        e.ir      = ins;
        e.ird     = (op >= 4'd1 && op <= 4'd4) ? S + 1 : 0;
        e.jrd     = (op == 4'd5) ? S + 1 : 0;
        case (op)
            4'd1:    e.st_mask = 4'b1000;
            4'd2:    e.st_mask = 4'b0100;
            4'd3:    e.st_mask = 4'b0010;
            4'd4:    e.st_mask = 4'b0001;
            4'd5:    e.st_mask = 4'b1000;
            default: e.st_mask = 4'b0000;
        endcase
        e.st_cnt  = (e.st_mask != 4'b0000) ? 1 : 0;
        e.pc      = (op == 4'd6 || (op == 4'd7 && !cy)) ? 2'b10 : 2'b01;
        e.cyc     = 3 + S;
        exp_q.push_back(e);
    endfunction

    // Per-instruction accumulators and global event counters.
    int         a_cyc, a_ird, a_jrd, a_other, a_st_cnt, a_pc_cyc, a_ill, a_viol;
    logic [3:0] a_st_mask;
    int         done_total, ill_total, st_total;

    function automatic void clear_acc();
        a_cyc = 0; a_ird = 0; a_jrd = 0; a_other = 0; a_st_cnt = 0;
        a_pc_cyc = 0; a_ill = 0; a_viol = 0; a_st_mask = 4'b0000;
    endfunction

    function automatic logic [9:0] n_vec();
        return {bif.nIRD_OUT, bif.nIRU_OUT, bif.nJRD_OUT, bif.nJRU_OUT,
                bif.nORD_ST, bif.nORU_ST, bif.nJRD_ST, bif.nJRU_ST,
                bif.nPC_OPEN, bif.nPC_LD};
    endfunction

    always @(negedge CLK) begin
        logic [3:0] outs_low, st_low;
        exp_t       e;
        if (!RST) begin
            clear_acc();
        end else begin
            outs_low = ~{bif.nIRD_OUT, bif.nIRU_OUT, bif.nJRD_OUT, bif.nJRU_OUT};
            st_low   = ~{bif.nORD_ST, bif.nORU_ST, bif.nJRD_ST, bif.nJRU_ST};
            if (st_low != 0) st_total++;
            if (bif.ILLEGAL) ill_total++;
            if ($countones(outs_low) > 1) a_viol++;
            if ($countones(st_low) > 1) a_viol++;
            if (st_low != 0 && outs_low == 0) a_viol++;
            if (!bif.nPC_OPEN && !bif.nPC_LD) a_viol++;
            if (bif.BUSY) begin
                a_cyc++;
                if (!bif.nIRD_OUT) a_ird++;
                if (!bif.nJRD_OUT) a_jrd++;
                if (!bif.nIRU_OUT || !bif.nJRU_OUT) a_other++;
                if (st_low != 0) a_st_cnt++;
                a_st_mask = a_st_mask | st_low;
                if (!bif.nPC_OPEN || !bif.nPC_LD) a_pc_cyc++;
                if (bif.ILLEGAL) a_ill++;
            end
            if (bif.DONE) begin
                done_total++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ir", 32'(bif.IR), 32'(e.ir));
                    check("ird_out_cycles", 32'(a_ird), 32'(e.ird));
                    check("jrd_out_cycles", 32'(a_jrd), 32'(e.jrd));
                    check("upper_out_cycles", 32'(a_other), 32'd0);
                    check("st_mask", 32'(a_st_mask), 32'(e.st_mask));
                    check("st_cycles", 32'(a_st_cnt), 32'(e.st_cnt));
                    check("pc_ld_open", 32'({!bif.nPC_LD, !bif.nPC_OPEN}), 32'(e.pc));
                    check("pc_cycles", 32'(a_pc_cyc), 32'd1);
                    check("latency", 32'(a_cyc), 32'(e.cyc));
                    check("illegal_pulses", 32'(a_ill), 32'd0);
                    check("invariants", 32'(a_viol), 32'd0);
                end
                clear_acc();
            end
        end
    end

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK);
            #2;
            if (exp_q.size() == 0) return;
        end
        check("timeout_done", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic pulse_step();
        @(negedge CLK);
        bif.STEP = 1'b1;
        @(negedge CLK);
        bif.STEP = 1'b0;
    endtask

    task automatic step_instr(input logic [7:0] ins, input logic cy);
        bif.INSTR = ins;
        bif.CARRY = cy;
        push_exp(ins, cy);
        pulse_step();
        wait_empty(40);
        repeat (2) @(negedge CLK);
    endtask

    logic [7:0] prog_ins[9] = '{8'h1A, 8'h2B, 8'h3C, 8'h4D, 8'h50, 8'h60, 8'h71, 8'h70, 8'h00};
    logic       prog_cy [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int  d0;
        bit  found;
        RST       = 1'b0;
        bif.RUN   = 1'b0;
        bif.STEP  = 1'b0;
        bif.INSTR = 8'h00;
        bif.CARRY = 1'b0;
        done_total = 0; ill_total = 0; st_total = 0;
        clear_acc();

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (i == 3) bif.STEP = 1'b1;
            if (i == 5) bif.STEP = 1'b0;
            check("rst_n_outputs", 32'(n_vec()), 32'h3FF);
            check("rst_ir", 32'(bif.IR), 32'h00);
            check("rst_status", 32'({bif.BUSY, bif.DONE, bif.ILLEGAL}), 32'd0);
        end
        @(negedge CLK);
        RST = 1'b1;
        repeat (6) @(negedge CLK);
        check("idle_after_rst_busy", 32'(bif.BUSY), 32'd0);
        check("idle_after_rst_done", 32'(done_total), 32'd0);

        step_instr(8'h1A, 1'b0);
        step_instr(8'h70, 1'b0);
        step_instr(8'h70, 1'b1);
        step_instr(8'h50, 1'b1);
        step_instr(8'h00, 1'b0);
        step_instr(8'h2F, 1'b0);
        step_instr(8'h61, 1'b1);
        step_instr(8'h45, 1'b0);

        // STEP pulsed again while busy must not start a second instruction.
        d0 = done_total;
        bif.INSTR = 8'h3C;
        bif.CARRY = 1'b0;
        push_exp(8'h3C, 1'b0);
        pulse_step();
        pulse_step();
        wait_empty(40);
        repeat (8) @(negedge CLK);
        check("step_while_busy_dones", 32'(done_total - d0), 32'd1);
        check("step_while_busy_idle", 32'(bif.BUSY), 32'd0);

        // Free run; RUN drops (with a stray STEP) during the final instruction.
        d0 = done_total;
        bif.INSTR = prog_ins[0];
        bif.CARRY = prog_cy[0];
        push_exp(prog_ins[0], prog_cy[0]);
        @(negedge CLK);
        bif.RUN = 1'b1;
        for (int i = 1; i < 9; i++) begin
            wait_empty(40);
            bif.INSTR = prog_ins[i];
            bif.CARRY = prog_cy[i];
            push_exp(prog_ins[i], prog_cy[i]);
        end
        bif.RUN = 1'b0;
        pulse_step();
        wait_empty(40);
        repeat (8) @(negedge CLK);
        check("run_stop_dones", 32'(done_total - d0), 32'd9);
        check("run_stop_idle", 32'(bif.BUSY), 32'd0);

        // Reset asserted during STORE aborts the instruction immediately.
        d0 = done_total;
        bif.INSTR = 8'h1A;
        bif.CARRY = 1'b0;
        push_exp(8'h1A, 1'b0);
        pulse_step();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (!bif.nORD_ST) found = 1'b1;
        end
        check("store_reached", 32'(found), 32'd1);
        #1 RST = 1'b0;
        #1;
        check("abort_ord_st", 32'(bif.nORD_ST), 32'd1);
        check("abort_ird_out", 32'(bif.nIRD_OUT), 32'd1);
        check("abort_busy", 32'(bif.BUSY), 32'd0);
        check("abort_ir", 32'(bif.IR), 32'h00);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (8) @(negedge CLK);
        check("abort_no_done", 32'(done_total - d0), 32'd0);

        // Illegal opcode parks in HALT.
        d0 = done_total;
        begin
            int i0, s0;
            i0 = ill_total;
            s0 = st_total;
            bif.INSTR = 8'hF3;
            pulse_step();
            repeat (12) @(negedge CLK);
            check("halt_illegal_pulses", 32'(ill_total - i0), 32'd1);
            check("halt_strobes", 32'(st_total - s0), 32'd0);
            check("halt_no_done", 32'(done_total - d0), 32'd0);
            check("halt_busy", 32'(bif.BUSY), 32'd0);
            check("halt_n_outputs", 32'(n_vec()), 32'h3FF);
            check("halt_ir", 32'(bif.IR), 32'hF3);
            bif.INSTR = 8'h1A;
            pulse_step();
            repeat (10) @(negedge CLK);
            check("halt_ignores_step", 32'({bif.BUSY, 8'(done_total - d0)}), 32'd0);
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        step_instr(8'h2C, 1'b0);

        repeat (4) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
